// File: rtl/bottle_counter_pkg.sv
// rtl/bottle_counter_pkg.sv - shared debounce state encodings and count width for the bottle counter
package bottle_counter_pkg;

    localparam int unsigned COUNT_W           = 13;
    localparam int unsigned DEFAULT_MAX_COUNT = 99;
    localparam int unsigned DEFAULT_DOZEN     = 12;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RISE    = 2'd1,
        S_PRESENT = 2'd2,
        S_FALL    = 2'd3
    } db_state_t;

endpackage

// File: rtl/bottle_counter_sensor_debounce.sv
// rtl/bottle_counter_sensor_debounce.sv - sensor synchroniser and debounce, one-cycle rise pulse (BOTTLE_DEBOUNCE_EN)
module sensor_debounce
    import bottle_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor,
    output logic rise_pulse
);

    logic sync1;
    logic s_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            s_sync <= 1'b0;
        end else begin
            sync1  <= sensor;
            s_sync <= sync1;
        end
    end

`ifdef BOTTLE_DEBOUNCE_EN
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    db_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Any state change, including a glitch abort, restarts the hold counter from zero
    always_comb begin
        state_nx   = state;
        cnt_nx     = '0;
        rise_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_sync) state_nx = S_RISE;
            end
            S_RISE: begin
                if (!s_sync) begin
                    state_nx = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = S_PRESENT;
                    rise_pulse = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_PRESENT: begin
                if (!s_sync) state_nx = S_FALL;
            end
            S_FALL: begin
                if (s_sync) begin
                    state_nx = S_PRESENT;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end
`else
    logic s_prev;
    logic unused_cfg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s_prev <= 1'b0;
        else          s_prev <= s_sync;
    end

    assign rise_pulse = s_sync & ~s_prev;
    assign unused_cfg = ^DEBOUNCE_CYCLES;
`endif

endmodule

// File: rtl/bottle_counter.sv
// rtl/bottle_counter.sv - saturating bottle count with dozen pulse; debounce selected by BOTTLE_DEBOUNCE_EN
module bottle_counter
    import bottle_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned MAX_COUNT       = DEFAULT_MAX_COUNT,
    parameter int unsigned DOZEN           = DEFAULT_DOZEN
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic               sensor,
    output logic [COUNT_W-1:0] count,
    output logic               bottle_evt,
    output logic               dozen_done,
    output logic               full
);

    localparam int unsigned TW = (DOZEN > 1) ? $clog2(DOZEN) : 1;
    localparam logic [TW-1:0]      TALLY_LAST = TW'(DOZEN - 1);
    localparam logic [COUNT_W-1:0] COUNT_PRE  = COUNT_W'(MAX_COUNT - 1);

    logic          rise_pulse;
    logic [TW-1:0] tally;
    logic          take;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .sensor    (sensor),
        .rise_pulse(rise_pulse)
    );

    // Clear outranks a coincident edge; a full counter ignores edges so it never wraps
    assign take = rise_pulse & enable & ~full & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            tally      <= '0;
            full       <= 1'b0;
            bottle_evt <= 1'b0;
            dozen_done <= 1'b0;
        end else begin
            bottle_evt <= 1'b0;
            dozen_done <= 1'b0;
            if (clear) begin
                count <= '0;
                tally <= '0;
                full  <= 1'b0;
            end else if (take) begin
                count      <= count + 1'b1;
                bottle_evt <= 1'b1;
                full       <= (count == COUNT_PRE);
                if (tally == TALLY_LAST) begin
                    tally      <= '0;
                    dozen_done <= 1'b1;
                end else begin
                    tally <= tally + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bottle_counter.sv
// tb/tb_bottle_counter.sv - directed self-checking bench for bottle_counter
module tb_bottle_counter;

`ifdef BOTTLE_DEBOUNCE_EN
    localparam int LAT       = 7;
    localparam int GLITCH_EV = 0;
`else
    localparam int LAT       = 3;
    localparam int GLITCH_EV = 5;
`endif

    logic        clk = 1'b0;
    logic        reset_n, enable, clear, sensor;
    logic [12:0] count;
    logic        bottle_evt, dozen_done, full;

    int tests = 0, fails = 0;
    int evt_cnt = 0, dz_cnt = 0, dz_alone = 0;
    int evt0, dz0;

    bottle_counter #(
        .DEBOUNCE_CYCLES(4),
        .MAX_COUNT      (99),
        .DOZEN          (12)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .sensor    (sensor),
        .count     (count),
        .bottle_evt(bottle_evt),
        .dozen_done(dozen_done),
        .full      (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bottle_evt) evt_cnt++;
        if (dozen_done) dz_cnt++;
        if (dozen_done && !bottle_evt) dz_alone++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bottle();
        sensor = 1'b1;
        tick(10);
        sensor = 1'b0;
        tick(10);
    endtask

    task automatic bottles(input int n);
        for (int i = 0; i < n; i++) bottle();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; sensor = 1'b0;
        tick(3);
        check("reset_count", int'(count), 0);
        check("reset_full", int'(full), 0);
        check("reset_evt", int'(bottle_evt), 0);
        reset_n = 1'b1;
        tick(20);
        check("idle_count", int'(count), 0);
        check("idle_pulses", evt_cnt + dz_cnt, 0);

        // single bottle, exact latency
        enable = 1'b1;
        evt0 = evt_cnt;
        sensor = 1'b1;
        tick(LAT - 1);
        check("lat_before", int'(count), 0);
        tick(1);
        check("lat_at", int'(count), 1);
        tick(10 - LAT);
        sensor = 1'b0;
        tick(10);
        check("single_evt", evt_cnt - evt0, 1);

        // short glitches
        evt0 = evt_cnt;
        for (int i = 0; i < 5; i++) begin
            sensor = 1'b1; tick(2);
            sensor = 1'b0; tick(6);
        end
        tick(10);
        check("glitch_evt", evt_cnt - evt0, GLITCH_EV);
        check("glitch_count", int'(count), 1 + GLITCH_EV);

        // one dozen
        do_clear();
        check("clear_count", int'(count), 0);
        evt0 = evt_cnt; dz0 = dz_cnt;
        bottles(11);
        check("dozen_11", dz_cnt - dz0, 0);
        bottle();
        check("dozen_count", int'(count), 12);
        check("dozen_done", dz_cnt - dz0, 1);
        check("dozen_evt", evt_cnt - evt0, 12);
        check("dozen_coinc", dz_alone, 0);

        // saturation
        do_clear();
        evt0 = evt_cnt; dz0 = dz_cnt;
        bottles(98);
        check("sat_98_count", int'(count), 98);
        check("sat_98_full", int'(full), 0);
        bottles(7);
        check("sat_count", int'(count), 99);
        check("sat_full", int'(full), 1);
        check("sat_evt", evt_cnt - evt0, 99);
        check("sat_dozen", dz_cnt - dz0, 8);
        do_clear();
        check("sat_clr_count", int'(count), 0);
        check("sat_clr_full", int'(full), 0);

        // clear coincident with the counting edge
        bottle();
        check("pre_clr_count", int'(count), 1);
        evt0 = evt_cnt;
        sensor = 1'b1;
        tick(LAT - 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(9 - LAT);
        sensor = 1'b0;
        tick(10);
        check("edge_clr_count", int'(count), 0);
        check("edge_clr_evt", evt_cnt - evt0, 0);

        // enable low, then bottle already present when enable rises
        enable = 1'b0;
        bottle();
        check("dis_count", int'(count), 0);
        sensor = 1'b1;
        tick(10);
        enable = 1'b1;
        tick(5);
        sensor = 1'b0;
        tick(10);
        check("present_count", int'(count), 0);
        bottle();
        check("reen_count", int'(count), 1);

        // reset in the middle of a debounce, sensor still high at release
        sensor = 1'b1;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        check("mid_rst_count", int'(count), 0);
        reset_n = 1'b1;
        evt0 = evt_cnt;
        tick(LAT + 2);
        check("mid_rst_after", int'(count), 1);
        tick(10);
        sensor = 1'b0;
        tick(10);
        check("mid_rst_once", evt_cnt - evt0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
